i2c_cmd_seq: RTL and testbench
==============================

I2C_CMD_SEQ -- requirements
Module: i2c_cmd_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DEPTH, default 4, SHALL set the command FIFO entry count (power of 2, 2..16).
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000, SHALL set the watchdog limit in clk cycles.
REQ-004 The ports SHALL be as follows:
- clk  in  1  system clock.
- arstn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_addr  in  7  target address.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_data  in  8  write byte.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rw  out  1  rw of the completed command.
- rsp_data  out  8  read byte (0 for writes).
- rsp_timeout  out  1  watchdog expired.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- i2c_start  out  1  one-cycle start pulse to the I2C master.
- addr  out  7  address to the master.
- rw  out  1  rw to the master.
- data_send  out  8  write byte to the master.
- i2c_done  in  1  master completion pulse.
- data_recv  in  8  master read byte.
- data_recv_done  in  1  master read-byte-valid pulse.

Function
REQ-005 The FIFO SHALL store {addr, rw, data} entries; a push SHALL occur when cmd_valid && cmd_ready.
REQ-006 cmd_ready SHALL be 1 exactly when the FIFO is not full; there SHALL be no bypass, so a push while full is refused even if a pop occurs in the same cycle.
REQ-007 A simultaneous push and pop SHALL leave the occupancy unchanged; the read and write pointers SHALL wrap modulo DEPTH.
REQ-008 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-009 IDLE: when the FIFO is non-empty, the FSM SHALL latch the head entry into addr/rw/data_send, pop it, and go to ISSUE the next cycle.
REQ-010 ISSUE: i2c_start SHALL be high for exactly this one cycle, the FSM SHALL clear the watchdog, and it SHALL go to WAIT.
REQ-011 addr, rw and data_send SHALL stay stable from ISSUE until the FSM leaves WAIT.
REQ-012 WAIT: on data_recv_done with rw = 1, rsp_data SHALL capture data_recv; on i2c_done the FSM SHALL go to RESP.
REQ-013 No i2c_start SHALL be issued while in WAIT or RESP, so exactly one master transaction is outstanding at a time.
REQ-014 RESP: rsp_valid SHALL be held high with rsp_rw/rsp_data/rsp_timeout stable until rsp_ready; on the handshake the FSM SHALL go to IDLE, so at least one cycle separates consecutive i2c_start pulses.
REQ-015 If rw = 0, rsp_data SHALL be 0x00.
REQ-016 If i2c_done and data_recv_done arrive in the same cycle, data SHALL be captured and the FSM SHALL go to RESP.
REQ-017 i2c_done arriving outside WAIT SHALL be ignored.

Reset
REQ-018 While arstn = 0 at a clk edge, the FSM SHALL go to IDLE and the FIFO SHALL be emptied.
REQ-019 After reset, all outputs SHALL be 0 except cmd_ready, which SHALL be 1.
REQ-020 Reset mid-transaction SHALL abandon the command without generating a response.

Configuration
REQ-021 With I2C_CMD_TIMEOUT_EN defined, a counter SHALL increment each WAIT cycle; on reaching TIMEOUT_CYCLES-1 without i2c_done, the FSM SHALL go to RESP with rsp_timeout = 1 and rsp_data = 0x00.
REQ-022 Without I2C_CMD_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL wait indefinitely, and rsp_timeout SHALL be tied to 0.

Verification
REQ-023 The bench SHALL cover the following scenarios:
- Write: push {0x50, 0, 0xA5}, model i2c_done 2000 cycles later -> one i2c_start pulse with addr 0x50/rw 0/data_send 0xA5; then rsp_valid with rsp_rw 0 and rsp_data 0x00.
- Read: push {0x3C, 1, x}, pulse data_recv_done with data_recv 0x7E, then i2c_done -> rsp_data 0x7E and rsp_rw 1.
- Fill: push 5 commands with DEPTH 4 and no pops -> cmd_ready 0 after the 4th; the 5th is held until the first pop; responses come out in order.
- Backpressure: hold rsp_ready 0 for 100 cycles -> no new i2c_start and rsp fields stable; on rsp_ready 1, the next command issues within 2 cycles.
- Timeout (I2C_CMD_TIMEOUT_EN, TIMEOUT_CYCLES 64): never assert i2c_done -> rsp_valid with rsp_timeout 1 exactly 64 cycles after ISSUE.
- Reset in WAIT with 2 commands queued -> busy 0, cmd_ready 1, no rsp_valid, no i2c_start afterwards.

Source files
------------

// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: buffers I2C commands in a small FIFO and hands them one at a time to an
// I2C byte master. Each command yields exactly one response, which is held until consumed.
// Optional feature: define I2C_CMD_TIMEOUT_EN to add a WAIT-state watchdog that forces a
// timeout response after TIMEOUT_CYCLES cycles without i2c_done.
module i2c_cmd_seq #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       arstn,
  // Command side
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_data,
  // Response side
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_rw,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       busy,
  // I2C master side
  output logic       i2c_start,
  output logic [6:0] addr,
  output logic       rw,
  output logic [7:0] data_send,
  input  logic       i2c_done,
  input  logic [7:0] data_recv,
  input  logic       data_recv_done
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i2c_cmd_seq: DEPTH must be a power of 2 in 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("i2c_cmd_seq: TIMEOUT_CYCLES must be at least 2");
  end

  // ---------------------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------------------
  logic [EntryW-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [EntryW-1:0] w_head;

  assign w_full    = (r_count == CntW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // No bypass: a full FIFO refuses the push even if the FSM pops in the same cycle.
  assign w_push    = cmd_valid && !w_full;
  assign w_head    = r_mem[r_rd_ptr];
  assign cmd_ready = !w_full;

  // Storage array: written on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_addr, cmd_rw, cmd_data};
    end
  end

  // Pointers wrap naturally at DEPTH (power of 2); occupancy tracks push/pop.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------------------
  state_e     r_state;
  state_e     w_state_d;
  logic       w_timeout;
  logic [6:0] r_addr;
  logic       r_rw;
  logic [7:0] r_data_send;
  logic [7:0] r_rsp_data;

`ifdef I2C_CMD_TIMEOUT_EN
  localparam int unsigned  WdogW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  logic [WdogW-1:0] r_wdog;
  logic [WdogW-1:0] w_wdog_inc;
  logic             r_timeout;

  assign w_wdog_inc = r_wdog + WdogW'(1);
  // Expires on the WAIT cycle whose increment reaches the limit; i2c_done takes priority.
  assign w_timeout  = (r_state == StWait) && !i2c_done && (w_wdog_inc == WdogLast);

  // Watchdog: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_wdog <= '0;
    end else if (r_state == StIssue) begin
      r_wdog <= '0;
    end else if (r_state == StWait) begin
      r_wdog <= w_wdog_inc;
    end
  end

  // Timeout flag for the current command; cleared when the next command is taken.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_timeout <= 1'b0;
    end else if (w_pop) begin
      r_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_timeout <= 1'b1;
    end
  end

  assign rsp_timeout = (r_state == StResp) && r_timeout;
`else
  assign w_timeout   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state decode plus FSM-derived strobes and outputs.
  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    i2c_start = 1'b0;
    rsp_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        i2c_start = 1'b1;
        w_state_d = StWait;
      end
      StWait: begin
        if (i2c_done || w_timeout) begin
          w_state_d = StResp;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Command latch and read-data capture. rsp_data starts at 0 for every command so writes
  // and timeouts report 0x00.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_data_send <= '0;
      r_rsp_data  <= '0;
    end else if (w_pop) begin
      {r_addr, r_rw, r_data_send} <= w_head;
      r_rsp_data                  <= '0;
    end else if (w_timeout) begin
      r_rsp_data <= '0;
    end else if ((r_state == StWait) && r_rw && data_recv_done) begin
      r_rsp_data <= data_recv;
    end
  end

  assign addr      = r_addr;
  assign rw        = r_rw;
  assign data_send = r_data_send;
  assign rsp_rw    = (r_state == StResp) && r_rw;
  assign rsp_data  = (r_state == StResp) ? r_rsp_data : 8'h00;
  assign busy      = !w_empty || (r_state != StIdle);

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Self-checking bench for i2c_cmd_seq: directed scenarios plus randomized batches, checked
// against a queue-based model of commands and issued transactions.
module tb_i2c_cmd_seq;

  typedef struct packed {
    logic [6:0] a;
    logic       rw;
    logic [7:0] d;
  } cmd_t;

  logic       clk;
  logic       arstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_rw;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic       busy;
  logic       i2c_start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] data_send;
  logic       i2c_done;
  logic [7:0] data_recv;
  logic       data_recv_done;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ntick   = 0;
  cmd_t exp_q[$];     // commands accepted, in order
  cmd_t starts_q[$];  // transactions seen on the master side, in order

  i2c_cmd_seq #(
    .DEPTH         (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk           (clk),
    .arstn         (arstn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_rw        (cmd_rw),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rw        (rsp_rw),
    .rsp_data      (rsp_data),
    .rsp_timeout   (rsp_timeout),
    .busy          (busy),
    .i2c_start     (i2c_start),
    .addr          (addr),
    .rw            (rw),
    .data_send     (data_send),
    .i2c_done      (i2c_done),
    .data_recv     (data_recv),
    .data_recv_done(data_recv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every start pulse with the command presented to the master.
  always @(posedge clk) begin
    if (i2c_start === 1'b1) starts_q.push_back({addr, rw, data_send});
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: bench did not finish, observed hang expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ntick++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input cmd_t c);
    int k;
    k         = 0;
    cmd_valid = 1'b1;
    {cmd_addr, cmd_rw, cmd_data} = c;
    while (cmd_ready !== 1'b1 && k < 500) begin
      tick();
      k++;
    end
    check("push_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back(c);
  endtask

  // Act as the master for the oldest outstanding command and consume its response.
  task automatic serve(input int lat, input logic [7:0] rd, input bit same, input int hold);
    cmd_t       e;
    cmd_t       s;
    bit         stable;
    int         k;
    logic [7:0] exp_d;
    e     = exp_q.pop_front();
    exp_d = e.rw ? rd : 8'h00;
    k     = 0;
    while (starts_q.size() == 0 && k < 500) begin
      tick();
      k++;
    end
    check("start_seen", starts_q.size() != 0, 1);
    if (starts_q.size() == 0) return;
    s = starts_q.pop_front();
    check("issue_cmd", s, e);
    stable = 1'b1;
    for (int i = 0; i < lat; i++) begin
      tick();
      if ({addr, rw, data_send} !== e || rsp_valid !== 1'b0) stable = 1'b0;
    end
    check("wait_stable", stable, 1);
    // Read-byte pulse is also sent for writes; it must be ignored there.
    if (!same) begin
      data_recv_done = 1'b1;
      data_recv      = rd;
      tick();
      data_recv_done = 1'b0;
      data_recv      = 8'($urandom);
    end
    i2c_done = 1'b1;
    if (same) begin
      data_recv_done = 1'b1;
      data_recv      = rd;
    end
    tick();
    i2c_done       = 1'b0;
    data_recv_done = 1'b0;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rw", rsp_rw, e.rw);
    check("rsp_data", rsp_data, exp_d);
    check("rsp_timeout", rsp_timeout, 0);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rw !== e.rw || rsp_data !== exp_d || rsp_timeout !== 1'b0
          || starts_q.size() != 0 || i2c_start !== 1'b0) stable = 1'b0;
    end
    check("rsp_hold", stable, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_gone", rsp_valid, 0);
  endtask

  initial begin
    cmd_t f;
    int   k;
    int   nb;
    int   t0;
    int   t1;
    bit   flag;

    arstn          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_addr       = '0;
    cmd_rw         = 1'b0;
    cmd_data       = '0;
    rsp_ready      = 1'b0;
    i2c_done       = 1'b0;
    data_recv      = '0;
    data_recv_done = 1'b0;
    repeat (3) tick();
    arstn = 1'b1;
    tick();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rw", rsp_rw, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_i2c_start", i2c_start, 0);
    check("rst_addr", addr, 0);
    check("rst_rw", rw, 0);
    check("rst_data_send", data_send, 0);

    // Stray i2c_done in IDLE is ignored
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    tick();
    check("stray_done_busy", busy, 0);
    check("stray_done_rsp", rsp_valid, 0);

    // Write with a slow master
    push({7'h50, 1'b0, 8'hA5});
    serve(2000, 8'h33, 1'b0, 0);
    tick();
    check("write_single_start", starts_q.size(), 0);
    check("write_idle", busy, 0);

    // Read, then read with data and done in the same cycle
    push({7'h3C, 1'b1, 8'h00});
    serve(3, 8'h7E, 1'b0, 0);
    push({7'h11, 1'b1, 8'h9F});
    serve(2, 8'hC3, 1'b1, 0);

    // Fill: one command in flight, four queued, fifth held
    push({7'h01, 1'b1, 8'h10});
    k = 0;
    while (starts_q.size() == 0 && k < 50) begin
      tick();
      k++;
    end
    for (int i = 2; i <= 5; i++) push({7'(i), 1'(i & 1), 8'(8'h10 + i)});
    check("fill_full", cmd_ready, 0);
    f         = {7'h06, 1'b0, 8'h16};
    cmd_valid = 1'b1;
    {cmd_addr, cmd_rw, cmd_data} = f;
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmd_ready !== 1'b0) flag = 1'b0;
    end
    check("fill_held", flag, 1);
    serve(4, 8'h5A, 1'b0, 0);
    check("fill_no_bypass", cmd_ready, 0);
    tick();
    check("fill_ready_after_pop", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back(f);
    check("fill_full_again", cmd_ready, 0);
    for (int i = 0; i < 5; i++) serve($urandom_range(0, 10), 8'($urandom), 1'b0, 0);

    // Backpressure on the response
    push({7'h22, 1'b1, 8'h00});
    push({7'h23, 1'b0, 8'h44});
    serve(5, 8'hB7, 1'b0, 100);
    k = 0;
    while (starts_q.size() == 0 && k < 2) begin
      tick();
      k++;
    end
    check("bp_next_issue", starts_q.size(), 1);
    serve(1, 8'h00, 1'b0, 0);

    // Randomized batches
    for (int b = 0; b < 6; b++) begin
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) push({7'($urandom), 1'($urandom), 8'($urandom)});
      for (int i = 0; i < nb; i++)
        serve($urandom_range(0, 20), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    // Watchdog
    push({7'h2A, 1'b1, 8'h00});
    k = 0;
    while (i2c_start !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("to_start", i2c_start, 1);
    t0 = ntick;
`ifdef I2C_CMD_TIMEOUT_EN
    tick();
    data_recv_done = 1'b1;
    data_recv      = 8'hFF;
    tick();
    data_recv_done = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    t1 = ntick;
    check("to_latency", t1 - t0, 64);
    check("to_flag", rsp_timeout, 1);
    check("to_data", rsp_data, 0);
    check("to_rw", rsp_rw, 1);
`else
    repeat (200) tick();
    t1 = ntick;
    check("nto_wait_len", t1 - t0, 200);
    check("nto_no_rsp", rsp_valid, 0);
    check("nto_busy", busy, 1);
    check("nto_flag", rsp_timeout, 0);
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    check("nto_rsp", rsp_valid, 1);
    check("nto_flag_rsp", rsp_timeout, 0);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("to_done_idle", rsp_valid, 0);
    starts_q.delete();
    exp_q.delete();

    // Reset while waiting with two commands queued
    push({7'h40, 1'b0, 8'h01});
    k = 0;
    while (starts_q.size() == 0 && k < 50) begin
      tick();
      k++;
    end
    push({7'h41, 1'b1, 8'h02});
    push({7'h42, 1'b0, 8'h03});
    check("rst2_busy_before", busy, 1);
    arstn = 1'b0;
    tick();
    arstn = 1'b1;
    starts_q.delete();
    exp_q.delete();
    check("rst2_busy", busy, 0);
    check("rst2_cmd_ready", cmd_ready, 1);
    check("rst2_rsp_valid", rsp_valid, 0);
    flag = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || i2c_start !== 1'b0 || busy !== 1'b0) flag = 1'b0;
    end
    check("rst2_quiet", flag, 1);
    check("rst2_no_start", starts_q.size(), 0);

    // Still usable after reset
    push({7'h55, 1'b1, 8'h00});
    serve(2, 8'h6D, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
